// File: rtl/jtag_ocimem_arbiter_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states, requester identities and
// default bus widths.
package jtag_ocimem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32'd8;
  localparam int unsigned DATA_W_DEF = 32'd32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    CAPTURE = 2'b10
  } state_e;

  typedef enum logic {
    REQ_JTAG = 1'b0,
    REQ_CPU  = 1'b1
  } req_e;

  function automatic req_e other_req(input req_e r);
    return (r == REQ_JTAG) ? REQ_CPU : REQ_JTAG;
  endfunction

endpackage

// File: rtl/jtag_ocimem_rr_pick.sv
// Two-way requester pick: round-robin between JTAG and CPU, with JTAG given
// absolute priority while the CPU sits in debug mode.
module jtag_ocimem_rr_pick
  import jtag_ocimem_arbiter_pkg::*;
(
  input  logic jtag_req_i,
  input  logic cpu_req_i,
  input  logic debugack_i,
  input  req_e last_grant_i,
  output logic valid_o,
  output req_e grant_o
);

  always_comb begin
    valid_o = 1'b0;
    grant_o = REQ_JTAG;
    if (jtag_req_i && cpu_req_i) begin
      valid_o = 1'b1;
      if (debugack_i) begin
        grant_o = REQ_JTAG;
      end else begin
        grant_o = other_req(last_grant_i);
      end
    end else if (jtag_req_i) begin
      valid_o = 1'b1;
      grant_o = REQ_JTAG;
    end else if (cpu_req_i) begin
      valid_o = 1'b1;
      grant_o = REQ_CPU;
    end else begin
      valid_o = 1'b0;
      grant_o = REQ_JTAG;
    end
  end

endmodule

// File: rtl/jtag_ocimem_arbiter.sv
// Arbitrates the single-port OCI RAM and the monitor data register between the
// JTAG sysclk action strobes and the CPU debug slave port.
module jtag_ocimem_arbiter
  import jtag_ocimem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              debugack_i,
  input  logic              jtag_addr_ld_i,
  input  logic [ADDR_W-1:0] jtag_addr_i,
  input  logic              jtag_req_i,
  input  logic              jtag_wr_i,
  input  logic [DATA_W-1:0] jtag_wdata_i,
  output logic              jtag_busy_o,
  output logic              jtag_done_o,
  output logic              jtag_err_o,
  output logic [DATA_W-1:0] mon_dreg_o,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_waitrequest_o,
  output logic [DATA_W-1:0] cpu_readdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  state_e            state_q;
  req_e              last_grant_q;
  req_e              owner_q;
  logic              op_wr_q;
  logic              pend_q;
  logic              pend_wr_q;
  logic [DATA_W-1:0] pend_wdata_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] mon_q;
  logic              wait_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  logic              cpu_act_d;
  logic              pick_valid_d;
  req_e              pick_grant_d;
  logic [ADDR_W-1:0] addr_cnt_inc_d;
  logic              capture_jtag_d;
  logic              capture_cpu_d;

  always_comb begin
    cpu_act_d      = cpu_read_i | cpu_write_i;
    addr_cnt_inc_d = addr_cnt_q + ADDR_W'(1);
    capture_jtag_d = (state_q == CAPTURE) && (owner_q == REQ_JTAG);
    capture_cpu_d  = (state_q == CAPTURE) && (owner_q == REQ_CPU);
  end

  jtag_ocimem_rr_pick u_pick (
    .jtag_req_i  (pend_q),
    .cpu_req_i   (cpu_act_d),
    .debugack_i  (debugack_i),
    .last_grant_i(last_grant_q),
    .valid_o     (pick_valid_d),
    .grant_o     (pick_grant_d)
  );

  // JTAG front end (pending flag, address counter, sticky error) plus the access FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_CPU;
      owner_q      <= REQ_JTAG;
      op_wr_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_wdata_q <= {DATA_W{1'b0}};
      addr_cnt_q   <= {ADDR_W{1'b0}};
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mon_q        <= {DATA_W{1'b0}};
      wait_q       <= 1'b1;
      rdata_q      <= {DATA_W{1'b0}};
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= {ADDR_W{1'b0}};
      ram_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      done_q   <= 1'b0;
      wait_q   <= 1'b1;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;

      // Set and clear of pend_q never collide: completion only happens while pending.
      if (jtag_req_i) begin
        if (pend_q) begin
          err_q <= 1'b1;
        end else begin
          pend_q       <= 1'b1;
          pend_wr_q    <= jtag_wr_i;
          pend_wdata_q <= jtag_wdata_i;
        end
      end
      if (jtag_addr_ld_i) begin
        if (pend_q) begin
          err_q <= 1'b1;
        end else begin
          addr_cnt_q <= jtag_addr_i;
        end
      end

      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            state_q      <= ACCESS;
            last_grant_q <= pick_grant_d;
            owner_q      <= pick_grant_d;
            ram_en_q     <= 1'b1;
            if (pick_grant_d == REQ_JTAG) begin
              op_wr_q     <= pend_wr_q;
              ram_we_q    <= pend_wr_q;
              ram_addr_q  <= addr_cnt_q;
              ram_wdata_q <= pend_wdata_q;
              if (pend_wr_q) begin
                done_q <= 1'b1;
                mon_q  <= pend_wdata_q;
              end
            end else begin
              op_wr_q     <= cpu_write_i;
              ram_we_q    <= cpu_write_i;
              ram_addr_q  <= cpu_addr_i;
              ram_wdata_q <= cpu_wdata_i;
              if (cpu_write_i) begin
                wait_q <= 1'b0;
              end
            end
          end
        end
        ACCESS: begin
          if (op_wr_q) begin
            state_q <= IDLE;
            if (owner_q == REQ_JTAG) begin
              pend_q     <= 1'b0;
              addr_cnt_q <= addr_cnt_inc_d;
            end
          end else begin
            // Read completion is flagged one cycle early so it lines up with ram_rdata.
            state_q <= CAPTURE;
            if (owner_q == REQ_JTAG) begin
              done_q <= 1'b1;
            end else begin
              wait_q <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          state_q <= IDLE;
          if (owner_q == REQ_JTAG) begin
            mon_q      <= ram_rdata_i;
            pend_q     <= 1'b0;
            addr_cnt_q <= addr_cnt_inc_d;
          end else begin
            rdata_q <= ram_rdata_i;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read data is forwarded straight from the RAM during CAPTURE, then held.
  always_comb begin
    jtag_busy_o       = pend_q;
    jtag_done_o       = done_q;
    jtag_err_o        = err_q;
    cpu_waitrequest_o = wait_q;
    ram_en_o          = ram_en_q;
    ram_we_o          = ram_we_q;
    ram_addr_o        = ram_addr_q;
    ram_wdata_o       = ram_wdata_q;
    mon_dreg_o        = capture_jtag_d ? ram_rdata_i : mon_q;
    cpu_readdata_o    = capture_cpu_d  ? ram_rdata_i : rdata_q;
  end

endmodule
